// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the write-back path.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    // One pending register-file write: destination index plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of pending register writes. Pointers carry one extra wrap
// bit so full/empty need no separate counter. Also reports, per entry, whether
// a valid entry targets the queried register.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  wb_req_t                 i_data,
    input  logic                    i_pop,
    input  logic [REG_ADDR_W-1:0]   i_rd_q,
    output wb_req_t                 o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [DEPTH-1:0]        o_match
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    wb_req_t      r_mem [DEPTH];

    logic         w_do_push;
    logic         w_do_pop;
    logic [AW:0]  w_count;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_count   = w_count;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        logic [AW-1:0] v_off;
        o_match = '0;
        v_off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            v_off      = AW'(i) - r_rd_ptr[AW-1:0];
            o_match[i] = ({1'b0, v_off} < w_count) && (r_mem[i].rd == i_rd_q);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: merges the ALU result channel and a
// buffered load-return channel onto the single write port. ALU has priority;
// a FIFO head that keeps losing is forced through after STARVE_MAX cycles.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [REG_ADDR_W-1:0]   ld_rd,
    input  logic [XLEN-1:0]         ld_data,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_rd,
    output logic [XLEN-1:0]         rf_wdata,
    input  logic [REG_ADDR_W-1:0]   chk_rs,
    output logic                    chk_busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic                   r_rf_we;
    logic [REG_ADDR_W-1:0]  r_rf_rd;
    logic [XLEN-1:0]        r_rf_wdata;
    logic [SW-1:0]          r_starve;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_alu_wr;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_starved;
    wb_req_t                w_head;
    wb_req_t                w_ld_req;
    logic [DEPTH-1:0]       w_match;

    assign w_starved = !w_empty && (r_starve >= SW'(STARVE_MAX));
    assign alu_ready = !w_starved;
    assign ld_ready  = !w_full;

    // rd==0 transfers are accepted but never reach the port or the queue.
    assign w_alu_wr  = alu_valid && alu_ready && (alu_rd != REG_ZERO);
    assign w_pop     = !w_empty && !w_alu_wr;
    assign w_push    = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    assign w_ld_req  = '{rd: ld_rd, data: ld_data};

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_ld_req),
        .i_pop   (w_pop),
        .i_rd_q  (chk_rs),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count),
        .o_match (w_match)
    );

    // Starvation counter: counts cycles a waiting head loses to the ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (r_starve < SW'(STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Registered write port; index and data hold when no write is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else if (w_alu_wr) begin
            r_rf_we    <= 1'b1;
            r_rf_rd    <= alu_rd;
            r_rf_wdata <= alu_data;
        end else if (w_pop) begin
            r_rf_we    <= 1'b1;
            r_rf_rd    <= w_head.rd;
            r_rf_wdata <= w_head.data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;

    assign chk_busy = (chk_rs != REG_ZERO) &&
                      ((|w_match) || (r_rf_we && (r_rf_rd == chk_rs)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_rs;
    logic        chk_busy;
    logic [2:0]  fifo_count;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wdata;
        logic        exp_busy;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .chk_rs     (chk_rs),
        .chk_busy   (chk_busy),
        .fifo_count (fifo_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Wait (bounded) until all expected writes have been observed.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_count0"}, {29'd0, fifo_count}, 0);
    endtask

    // Scoreboard: every observed write must match the next expected one.
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", rf_rd, rf_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_rd", {27'd0, rf_rd}, {27'd0, w.rd});
                check("wr_data", rf_wdata, w.data);
            end
        end
    end

    initial begin
        int next_rd;
        int li;
        int ai;
        logic exp_rdy[7];
        logic [2:0] f_cnt[6];
        logic f_ld[6];
        logic f_alu[6];

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 5'd7,  32'h22222222, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
        vecs[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  32'h00000001, 1'b0};
        vecs[5] = '{1'b1, 5'd0,  32'h00000000, 1'b0, 5'd1,  32'h00000001, 1'b0};

        idle_inputs();
        chk_rs = '0;
        reset  = 1'b1;
        tick();
        tick();
        check("rst_we", {31'd0, rf_we}, 0);
        check("rst_rd", {27'd0, rf_rd}, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_count", {29'd0, fifo_count}, 0);
        reset = 1'b0;
        tick();

        // Table: ALU-only traffic, including dropped rd==0 and idle cycles.
        chk_rs = 5'd5;
        foreach (vecs[i]) begin
            alu_valid = vecs[i].alu_valid;
            alu_rd    = vecs[i].alu_rd;
            alu_data  = vecs[i].alu_data;
            if (vecs[i].exp_we) push_exp(vecs[i].exp_rd, vecs[i].exp_wdata);
            #1;
            check("tbl_alu_ready", {31'd0, alu_ready}, 1);
            check("tbl_ld_ready", {31'd0, ld_ready}, 1);
            tick();
            check("tbl_we", {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
            check("tbl_rd", {27'd0, rf_rd}, {27'd0, vecs[i].exp_rd});
            check("tbl_wdata", rf_wdata, vecs[i].exp_wdata);
            check("tbl_busy", {31'd0, chk_busy}, {31'd0, vecs[i].exp_busy});
        end
        idle_inputs();
        drain("tbl");

        // Single load: two-cycle latency, hazard query covers queue and port.
        chk_rs   = 5'd7;
        ld_valid = 1'b1;
        ld_rd    = 5'd7;
        ld_data  = 32'h00001234;
        push_exp(5'd7, 32'h00001234);
        #1;
        check("ld_busy_pre", {31'd0, chk_busy}, 0);
        tick();
        idle_inputs();
        #1;
        check("ld_count1", {29'd0, fifo_count}, 1);
        check("ld_busy_q", {31'd0, chk_busy}, 1);
        check("ld_we_early", {31'd0, rf_we}, 0);
        tick();
        check("ld_we", {31'd0, rf_we}, 1);
        check("ld_rd", {27'd0, rf_rd}, 7);
        check("ld_busy_port", {31'd0, chk_busy}, 1);
        tick();
        check("ld_we_off", {31'd0, rf_we}, 0);
        check("ld_busy_off", {31'd0, chk_busy}, 0);
        chk_rs = 5'd0;
        drain("ld");

        // Starvation: continuous ALU, one load at rd 9.
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        push_exp(5'd1, 32'h1001);
        push_exp(5'd2, 32'h1002);
        push_exp(5'd3, 32'h1003);
        push_exp(5'd4, 32'h1004);
        push_exp(5'd9, 32'h00000099);
        push_exp(5'd5, 32'h1005);
        push_exp(5'd6, 32'h1006);
        next_rd = 1;
        for (int k = 0; k < 7; k++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(next_rd);
            alu_data  = 32'h1000 + 32'(next_rd);
            ld_valid  = (k == 0);
            ld_rd     = 5'd9;
            ld_data   = 32'h00000099;
            #1;
            check("stv_alu_ready", {31'd0, alu_ready}, {31'd0, exp_rdy[k]});
            if (alu_ready) next_rd++;
            tick();
        end
        idle_inputs();
        drain("stv");

        // FIFO fill with ALU saturating; fifth load waits for the first pop.
        f_cnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
        f_ld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        f_alu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        push_exp(5'd16, 32'h2010);
        push_exp(5'd17, 32'h2011);
        push_exp(5'd18, 32'h2012);
        push_exp(5'd19, 32'h2013);
        push_exp(5'd10, 32'h5000A);
        push_exp(5'd20, 32'h2014);
        push_exp(5'd11, 32'h5000B);
        push_exp(5'd12, 32'h5000C);
        push_exp(5'd13, 32'h5000D);
        push_exp(5'd14, 32'h5000E);
        li = 0;
        ai = 0;
        for (int k = 0; k < 6; k++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(16 + ai);
            alu_data  = 32'h2010 + 32'(ai);
            ld_valid  = (li < 5);
            ld_rd     = 5'(10 + li);
            ld_data   = 32'h5000A + 32'(li);
            #1;
            check("full_count", {29'd0, fifo_count}, {29'd0, f_cnt[k]});
            check("full_ld_ready", {31'd0, ld_ready}, {31'd0, f_ld[k]});
            check("full_alu_ready", {31'd0, alu_ready}, {31'd0, f_alu[k]});
            if (ld_ready && ld_valid) li++;
            if (alu_ready) ai++;
            tick();
        end
        idle_inputs();
        check("full_loads_taken", li, 5);
        drain("full");

        // ALU rd 0 alongside a waiting head: head writes the same cycle.
        ld_valid = 1'b1;
        ld_rd    = 5'd3;
        ld_data  = 32'h00000033;
        push_exp(5'd3, 32'h00000033);
        tick();
        idle_inputs();
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h00000BAD;
        #1;
        check("z_alu_ready", {31'd0, alu_ready}, 1);
        tick();
        idle_inputs();
        check("z_we", {31'd0, rf_we}, 1);
        check("z_rd", {27'd0, rf_rd}, 3);
        check("z_wdata", rf_wdata, 32'h00000033);
        drain("z");

        // Reset with three loads queued behind ALU traffic.
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(20 + k);
            alu_data  = 32'h3000 + 32'(k);
            ld_valid  = 1'b1;
            ld_rd     = 5'(24 + k);
            ld_data   = 32'h4000 + 32'(k);
            if (k < 2) push_exp(5'(20 + k), 32'h3000 + 32'(k));
            tick();
        end
        idle_inputs();
        check("rst_mid_count3", {29'd0, fifo_count}, 3);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("rst_mid_count0", {29'd0, fifo_count}, 0);
        check("rst_mid_we", {31'd0, rf_we}, 0);
        tick();
        tick();
        check("rst_mid_rd", {27'd0, rf_rd}, 0);
        check("rst_mid_wdata", rf_wdata, 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("rst_after_count", {29'd0, fifo_count}, 0);
        check("rst_after_we", {31'd0, rf_we}, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
